uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter peripheral on the picorv32 native memory bus.
- Sits in the MMUP region beside PORTA.
- The CPU writes bytes into an 8-entry FIFO; a baud-timed FSM serialises them 8N1, LSB first, on tx.
- Provides a registered mem_ready/mem_rdata response for the SoC ready mux, and a level interrupt routed to an SoC irq input.

---
 rtl/uart_tx_mmio.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus.
// A byte FIFO feeds a baud-timed serialiser; a level irq flags "drained and idle".
module uart_tx_mmio #(
  parameter logic [31:0] BASE       = 32'h0010_0010,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq_tx
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_DIV    = 2'd3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic [15:0]     baud_cnt;
  logic [15:0]     period;

  logic            ctrl_txen;
  logic            ctrl_irqen;
  logic [15:0]     div_q;
  logic            ovf;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            sel_c, acc_c, wr_c, rd_c;
  logic [1:0]      reg_off_c;
  logic            push_c, push_ok_c, pop_c;
  logic            full_c, empty_c, busy_c;
  logic [7:0]      fifo_head_c;
  logic [15:0]     div_eff_c;
  logic            bit_end_c;
  logic [31:0]     status_c;
  logic [31:0]     rdata_c;
  logic            unused_c;

  // Bus decode: an access is taken only on the cycle before the ready pulse.
  assign sel_c     = mem_valid && (mem_addr[31:4] == BASE[31:4]);
  assign acc_c     = sel_c && !mem_ready;
  assign wr_c      = acc_c && (mem_wstrb != 4'b0000);
  assign rd_c      = acc_c && (mem_wstrb == 4'b0000);
  assign reg_off_c = mem_addr[3:2];

  assign full_c      = (count == FULL_CNT);
  assign empty_c     = (count == CW'(0));
  assign busy_c      = (state != IDLE);
  assign fifo_head_c = fifo_mem[rd_ptr];

  assign push_c    = wr_c && (reg_off_c == OFF_DATA) && mem_wstrb[0];
  assign pop_c     = (state == IDLE) && ctrl_txen && !empty_c;
  assign push_ok_c = push_c && (!full_c || pop_c);

  assign div_eff_c = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_end_c = (baud_cnt == period - 16'd1);

  assign status_c = {24'b0, 4'(count), ovf, empty_c, full_c, busy_c};

  assign unused_c = ^{mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

  always_comb begin
    rdata_c = 32'b0;
    case (reg_off_c)
      OFF_STATUS: rdata_c = status_c;
      OFF_CTRL:   rdata_c = {30'b0, ctrl_irqen, ctrl_txen};
      OFF_DIV:    rdata_c = {16'b0, div_q};
      default:    rdata_c = 32'b0;
    endcase
  end

  // Registered bus response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'b0;
    end else begin
      mem_ready <= sel_c && !mem_ready;
      mem_rdata <= rd_c ? rdata_c : 32'b0;
    end
  end

  // Control, divisor and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_txen  <= 1'b0;
      ctrl_irqen <= 1'b0;
      div_q      <= DIV_RESET;
      ovf        <= 1'b0;
    end else begin
      if (push_c && full_c && !pop_c) begin
        ovf <= 1'b1;
      end else if (wr_c && (reg_off_c == OFF_STATUS) && mem_wstrb[0] && mem_wdata[3]) begin
        ovf <= 1'b0;
      end
      if (wr_c && (reg_off_c == OFF_CTRL) && mem_wstrb[0]) begin
        ctrl_txen  <= mem_wdata[0];
        ctrl_irqen <= mem_wdata[1];
      end
      if (wr_c && (reg_off_c == OFF_DIV)) begin
        if (mem_wstrb[0]) div_q[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) div_q[15:8] <= mem_wdata[15:8];
      end
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  // Serialiser: tx is registered alongside the state so line level tracks the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      baud_cnt <= 16'd0;
      period   <= 16'd1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop_c) begin
            shreg    <= fifo_head_c;
            state    <= START;
            tx       <= 1'b0;
            baud_cnt <= 16'd0;
            period   <= div_eff_c;
          end
        end
        START: begin
          if (bit_end_c) begin
            state    <= DATA;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= 3'd0;
            baud_cnt <= 16'd0;
            period   <= div_eff_c;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_cnt <= 16'd0;
            period   <= div_eff_c;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end_c) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_tx <= 1'b0;
    end else begin
      irq_tx <= ctrl_irqen && empty_c && (state == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vector table, serial scoreboard
// and cycle-exact frame sequences.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0010_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        irq_tx;

  uart_tx_mmio #(
    .BASE      (BASE),
    .FIFO_DEPTH(8),
    .DIV_RESET (16'd868)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .tx       (tx),
    .irq_tx   (irq_tx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rdy;
    logic [31:0] rdata;
    logic        irq;
  } vec_t;

  vec_t        vt [17];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  logic        mon_en = 1'b1;
  int          mon_p = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One bus access; expected read data goes through the rd_q scoreboard.
  task automatic bus_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic exp_rdy, input logic [31:0] exp_rd);
    logic        got;
    int          cyc;
    logic [31:0] rd;
    logic [31:0] want;
    if (exp_rdy) rd_q.push_back(exp_rd);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    got = 1'b0;
    cyc = 0;
    rd  = 32'h0;
    while (!got && cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) begin
        got = 1'b1;
        rd  = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    check($sformatf("ready@%08h", a), 32'(got), 32'(exp_rdy));
    if (exp_rdy) begin
      want = rd_q.pop_front();
      if (got) begin
        check($sformatf("latency@%08h", a), cyc, 1);
        check($sformatf("rdata@%08h", a), rd, want);
      end
    end
    @(posedge clk); #1;
    check("ready_pulse", 32'(mem_ready), 32'h0);
    check("rdata_idle", mem_rdata, 32'h0);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int p, input int k);
    int idx;
    idx = k / p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic wait_start();
    int w;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (tx !== 1'b0 && w < 40);
    check("frame_start", 32'(tx), 32'h0);
  endtask

  // Cycle-exact check of one frame, or two frames separated by the one-cycle IDLE gap.
  task automatic watch(input logic [7:0] b0, input logic [7:0] b1, input int p,
                       input int nfr, input logic chk_irq);
    int   l;
    int   t;
    logic e_tx;
    logic e_irq;
    l = 10 * p;
    t = (nfr == 2) ? 2 * l + 1 : l;
    wait_start();
    for (int k = 0; k <= t + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k < l)                               e_tx = frame_bit(b0, p, k);
      else if (nfr == 2 && k > l && k <= 2*l)  e_tx = frame_bit(b1, p, k - l - 1);
      else                                     e_tx = 1'b1;
      e_irq = chk_irq && (k > t);
      check($sformatf("tx[%0d]", k), 32'(tx), 32'(e_tx));
      check($sformatf("irq[%0d]", k), 32'(irq_tx), 32'(e_irq));
    end
  endtask

  // Serial monitor: decodes mid-bit samples and pops the expected byte.
  initial begin : serial_mon
    logic [9:0] bits;
    logic [7:0] want;
    int         p;
    forever begin
      @(posedge clk); #1;
      if (mon_en && !reset && tx === 1'b0) begin
        p = mon_p;
        bits = '0;
        for (int k = 0; k < 10 * p; k++) begin
          if (k > 0) begin
            @(posedge clk); #1;
          end
          if (k % p == p / 2) bits[k/p] = tx;
        end
        if (tx_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL serial_unexpected: got frame 0x%02h, want no frame", bits[8:1]);
        end else begin
          want = tx_q.pop_front();
          check("serial_byte", 32'(bits[8:1]), 32'(want));
          check("serial_stop", 32'(bits[9]), 32'h1);
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin : main
    int lows;

    vt[0]  = '{BASE + 32'h4, 32'h0,         4'h0, 1'b1, 32'h0000_0004, 1'b0};
    vt[1]  = '{BASE + 32'h8, 32'h0,         4'h0, 1'b1, 32'h0000_0000, 1'b0};
    vt[2]  = '{BASE + 32'hC, 32'h0,         4'h0, 1'b1, 32'h0000_0364, 1'b0};
    vt[3]  = '{BASE + 32'h0, 32'h0,         4'h0, 1'b1, 32'h0000_0000, 1'b0};
    vt[4]  = '{BASE + 32'h8, 32'h2,         4'h1, 1'b1, 32'h0000_0000, 1'b1};
    vt[5]  = '{BASE + 32'h8, 32'h0,         4'h0, 1'b1, 32'h0000_0002, 1'b1};
    vt[6]  = '{BASE + 32'hC, 32'h1234,      4'h2, 1'b1, 32'h0000_0000, 1'b1};
    vt[7]  = '{BASE + 32'hC, 32'h0,         4'h0, 1'b1, 32'h0000_1264, 1'b1};
    vt[8]  = '{BASE + 32'hC, 32'h5,         4'h1, 1'b1, 32'h0000_0000, 1'b1};
    vt[9]  = '{BASE + 32'hC, 32'h0,         4'h0, 1'b1, 32'h0000_1205, 1'b1};
    vt[10] = '{BASE + 32'h8, 32'h0,         4'h1, 1'b1, 32'h0000_0000, 1'b0};
    vt[11] = '{32'h0010_0020, 32'h0,        4'h0, 1'b0, 32'h0000_0000, 1'b0};
    vt[12] = '{32'h0010_0000, 32'h0,        4'h0, 1'b0, 32'h0000_0000, 1'b0};
    vt[13] = '{32'h0010_0020, 32'h55,       4'h1, 1'b0, 32'h0000_0000, 1'b0};
    vt[14] = '{BASE + 32'h4, 32'h0,         4'h0, 1'b1, 32'h0000_0004, 1'b0};
    vt[15] = '{BASE + 32'hC, 32'hFFFF_0000, 4'hC, 1'b1, 32'h0000_0000, 1'b0};
    vt[16] = '{BASE + 32'hC, 32'h0,         4'h0, 1'b1, 32'h0000_1205, 1'b0};

    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_irq", 32'(irq_tx), 32'h0);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    reset = 1'b0;

    // Register map and window decode.
    for (int i = 0; i < 17; i++) begin
      bus_access(vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].rdy, vt[i].rdata);
      check($sformatf("irq_vec%0d", i), 32'(irq_tx), 32'(vt[i].irq));
    end
    check("tx_idle", 32'(tx), 32'h1);

    // 0xA5 at DIV=4: exact waveform, BUSY while sending.
    bus_access(BASE + 32'hC, 32'd4, 4'h3, 1'b1, 32'h0);
    bus_access(BASE + 32'h8, 32'd1, 4'h1, 1'b1, 32'h0);
    mon_p = 4;
    tx_q.push_back(8'hA5);
    fork
      begin
        bus_access(BASE, 32'hA5, 4'h1, 1'b1, 32'h0);
        repeat (5) @(posedge clk);
        bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h05);
        repeat (10) @(posedge clk);
        bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h05);
      end
      watch(8'hA5, 8'h00, 4, 1, 1'b0);
    join
    bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h04);
    check("serial_drained_a5", tx_q.size(), 32'h0);

    // Overflow with TXEN clear, then OVF write-one-to-clear.
    bus_access(BASE + 32'h8, 32'd0, 4'h1, 1'b1, 32'h0);
    for (int i = 0; i < 9; i++) begin
      bus_access(BASE, 32'(i), 4'h1, 1'b1, 32'h0);
    end
    bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h8A);
    bus_access(BASE + 32'h4, 32'h8, 4'h1, 1'b1, 32'h0);
    bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h82);
    check("tx_held_txen0", 32'(tx), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h04);

    // Back-to-back frames at DIV=2 with interrupt enabled.
    bus_access(BASE + 32'hC, 32'd2, 4'h3, 1'b1, 32'h0);
    bus_access(BASE + 32'h8, 32'd3, 4'h1, 1'b1, 32'h0);
    check("irq_empty_idle", 32'(irq_tx), 32'h1);
    mon_p = 2;
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC3);
    fork
      begin
        bus_access(BASE, 32'h3C, 4'h1, 1'b1, 32'h0);
        bus_access(BASE, 32'hC3, 4'h1, 1'b1, 32'h0);
      end
      watch(8'h3C, 8'hC3, 2, 2, 1'b1);
    join
    check("serial_drained_b2b", tx_q.size(), 32'h0);

    // Reset during the DATA phase of 0x5A.
    mon_en = 1'b0;
    bus_access(BASE + 32'hC, 32'd4, 4'h3, 1'b1, 32'h0);
    bus_access(BASE + 32'h8, 32'd1, 4'h1, 1'b1, 32'h0);
    fork
      bus_access(BASE, 32'h5A, 4'h1, 1'b1, 32'h0);
      begin
        wait_start();
        repeat (12) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("tx_on_reset", 32'(tx), 32'h1);
        check("irq_on_reset", 32'(irq_tx), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h04);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    check("tx_quiet_after_reset", lows, 0);
    bus_access(BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h364);
    bus_access(BASE + 32'h8, 32'h0, 4'h0, 1'b1, 32'h0);
    mon_en = 1'b1;

    // DIV=0 behaves as one cycle per bit.
    bus_access(BASE + 32'hC, 32'd0, 4'h3, 1'b1, 32'h0);
    bus_access(BASE + 32'h8, 32'd1, 4'h1, 1'b1, 32'h0);
    mon_p = 1;
    tx_q.push_back(8'h96);
    fork
      bus_access(BASE, 32'h96, 4'h1, 1'b1, 32'h0);
      watch(8'h96, 8'h00, 1, 1, 1'b0);
    join
    bus_access(BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h0);
    bus_access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h04);
    check("serial_drained_div0", tx_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
